uart_tx_byte: RTL
=================

Name: uart_tx_byte

Overview:
- Byte-wide UART transmitter instantiated inside the TinyTapeout user top.
- Sits directly downstream of the dedicated-input bus: the top presents ui_in as tx_data with a valid strobe, and drives tx onto uo_out[0].
- Serialises one 8N1 frame per accepted byte, or 8E1 when parity is enabled.
- Uses a valid/ready handshake so the top can stream bytes back-to-back.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per serial bit. Legal range is 2..65535; the counter width is derived from it.
- PARITY_EN, 0: 1 inserts an even-parity bit between data bit 7 and the stop bit.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design-selected enable; gates acceptance of new bytes only.
- tx_data  input  8  byte to send; sampled only on an accept.
- tx_valid  input  1  upstream has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  high from the start bit through the last stop-bit cycle.
- frame_done  output  1  one-cycle pulse after a frame completes.

Behaviour:
- Reset values (rst_n low, asynchronous): tx=1, busy=0, frame_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0. tx_ready=0 while rst_n is low.
- tx_ready is combinational: (state==IDLE) && ena && rst_n.
- Accept occurs on a rising clk edge with tx_valid && tx_ready. tx_data is captured into the shift register, and the parity bit is computed as XOR of tx_data. Later changes on tx_data are ignored.
- All outputs are registered except tx_ready.
- States:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after 8 bits if PARITY_EN=1, otherwise DATA -> STOP.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Latency: tx drops to 0 on the same edge that accepts the byte. Each bit holds tx for exactly CLKS_PER_BIT cycles.
- Bit order: data is sent LSB first. Line levels: start=0, stop=1, parity=XOR of data bits (even parity).
- Frame length is (10+PARITY_EN)*CLKS_PER_BIT cycles, measured from the accept edge to the edge that returns the block to IDLE.
- busy=1 in every non-IDLE state.
- frame_done=1 for exactly the first IDLE cycle after STOP.
- Back-to-back: tx_ready is high in that same first IDLE cycle. An accept there starts the next start bit on that edge. The idle-high gap between frames is therefore exactly 1 clock.
- ena deasserted mid-frame: the current frame completes normally, and no new byte is accepted until ena returns high. ena low has no effect on tx when idle (tx stays 1).
- tx_valid high while busy: ignored, no capture. Upstream must hold the byte until tx_ready.
- Reset mid-frame: tx goes to 1 immediately (asynchronously) and the frame is abandoned. After rst_n rises the block is in IDLE and the next accept sends a full frame.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary. There is no drift across bits.

Test Plan:
- (All scenarios use CLKS_PER_BIT=4.)
- PARITY_EN=0, send 0x55 -> tx holds 0,1,0,1,0,1,0,1,0,1, each for 4 cycles (40 cycles total). busy=1 for all 40. frame_done pulses on cycle 41. tx_ready is low during the frame.
- PARITY_EN=1, send 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity=1, then stop=1 (44 cycles). Repeat with 0x03 -> parity=0.
- Back-to-back 0xA5 then 0x3C with tx_valid held high -> second start bit begins exactly 1 cycle after the first stop bit ends. Both bytes decode correctly LSB-first.
- Change tx_data from 0x81 to 0xFF one cycle after accept -> the line still carries 0x81.
- Deassert rst_n at cycle 15 of a 0x00 frame -> tx=1 within the same cycle and busy=0. After release, an accept of 0xF0 produces a full correct frame.
- ena=0 with tx_valid=1 -> tx_ready=0 and tx stays 1 for 50 cycles. Drop ena mid-frame -> the frame finishes intact and no further accept occurs.

Source files
------------

// File: rtl/uart_tx_byte_if.sv
// Byte handshake between the upstream source and the UART transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface uart_tx_byte_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter: 8N1 frames, or 8E1 with PARITY_EN.
// Valid/ready input so bytes can stream with a one-clock idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  uart_tx_byte_if.slave bus,
  output logic tx,
  output logic busy,
  output logic frame_done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;

  logic          accept;
  logic          baud_done;
  logic          last_bit;
  logic          tx_d;
  logic          busy_d;
  logic          done_d;

  assign bus.tx_ready = (state == IDLE) && ena && rst_n;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign baud_done    = (baud_cnt == BAUD_LAST);
  assign last_bit     = (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = START;
      end
      START: begin
        if (baud_done) state_n = DATA;
      end
      DATA: begin
        if (baud_done && last_bit)
          state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (baud_done) state_n = STOP;
      end
      STOP: begin
        if (baud_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is registered, so each level is chosen one edge ahead
  always_comb begin
    tx_d   = tx;
    busy_d = (state_n != IDLE);
    done_d = (state == STOP) && baud_done;
    unique case (1'b1)
      accept: tx_d = 1'b0;
      (state == START) && baud_done:
        tx_d = shreg[0];
      (state == DATA) && baud_done && !last_bit:
        tx_d = shreg[1];
      (state == DATA) && baud_done && last_bit:
        tx_d = PARITY_EN ? par : 1'b1;
      (state == PARITY) && baud_done:
        tx_d = 1'b1;
      (state == STOP) && baud_done:
        tx_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
    end else begin
      if (state == IDLE || baud_done)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (accept) begin
        shreg   <= bus.tx_data;
        par     <= ^bus.tx_data;
        bit_cnt <= '0;
      end else if (state == DATA && baud_done) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
